// File: rtl/alu_muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq_pkg
// Shared encodings for the iterative multiply/divide unit: operation codes
// as presented on op_i, and the controller state encoding.
// ---------------------------------------------------------------------------
package alu_muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,  // low word of product
    OP_MULHU = 2'b01,  // high word of product
    OP_DIVU  = 2'b10,  // quotient
    OP_REMU  = 2'b11   // remainder
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Both divide operations share the upper encoding bit.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the shared shift-add multiplier /
// restoring divider datapath.
//   div_mode : 0 = multiply step, 1 = divide step
//   hi_cur   : product high word (multiply) / partial remainder (divide)
//   lo_cur   : product low word + remaining multiplier bits (multiply) /
//              dividend bits being shifted out + quotient bits (divide)
//   operand  : multiplicand (multiply) / divisor (divide)
//   hi_next, lo_next : register pair after this iteration
// ---------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi_cur,
  input  logic [WIDTH-1:0] lo_cur,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;
  logic           no_borrow;

  always_comb begin
    // Multiply: conditional add with carry, then {carry,hi,lo} >> 1.
    mul_sum   = {1'b0, hi_cur} + (lo_cur[0] ? {1'b0, operand} : '0);

    // Divide: {rem,quo} << 1. The bit shifted out of rem is kept so divisors
    // above 2^(WIDTH-1) still divide correctly; when it is set the shifted
    // remainder already exceeds any divisor.
    rem_shift = {hi_cur, lo_cur[WIDTH-1]};
    trial     = rem_shift - {1'b0, operand};
    no_borrow = rem_shift[WIDTH] | ~trial[WIDTH];

    if (div_mode) begin
      if (no_borrow) begin
        hi_next = trial[WIDTH-1:0];
        lo_next = {lo_cur[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_shift[WIDTH-1:0];
        lo_next = {lo_cur[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_cur[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one bit per clock over a
// shared datapath. Fixed latency: WIDTH busy cycles, then a one-cycle done.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous reset, active high
//   start_i   : launch request, honoured in IDLE or DONE only
//   op_i      : 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a_i, b_i  : multiplicand/dividend, multiplier/divisor
//   busy_o    : high while iterating
//   done_o    : one-cycle pulse, result_o valid
//   result_o  : selected result, held until the next accepted start
//   divzero_o : with done_o, divide op with a zero divisor
// ---------------------------------------------------------------------------
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             divzero_o
);

  state_e             state_reg;
  op_e                op_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   operand_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               divzero_reg;

  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [WIDTH-1:0]   result_next;
  logic               start_div;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (op_is_div(op_reg)),
    .hi_cur   (hi_reg),
    .lo_cur   (lo_reg),
    .operand  (operand_reg),
    .hi_next  (hi_next),
    .lo_next  (lo_next)
  );

  // Result is taken from the final iteration's outputs so it can be
  // registered on the same edge the FSM enters DONE.
  always_comb begin
    result_next = lo_next;
    case (op_reg)
      OP_MUL:   result_next = lo_next;
      OP_MULHU: result_next = hi_next;
      OP_DIVU:  result_next = lo_next;
      OP_REMU:  result_next = hi_next;
      default:  result_next = lo_next;
    endcase
  end

  assign start_div = op_i[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= S_IDLE;
      op_reg      <= OP_MUL;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      operand_reg <= '0;
      result_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      divzero_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      divzero_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            // lo starts with the multiplier (MUL) or the dividend (DIV);
            // the other operand stays fixed for every iteration.
            op_reg      <= op_e'(op_i);
            hi_reg      <= '0;
            lo_reg      <= start_div ? a_i : b_i;
            operand_reg <= start_div ? b_i : a_i;
            cnt_reg     <= CNT_W'(WIDTH - 1);
            busy_reg    <= 1'b1;
            state_reg   <= S_RUN;
          end else begin
            state_reg   <= S_IDLE;
          end
        end
        S_RUN: begin
          hi_reg <= hi_next;
          lo_reg <= lo_next;
          if (cnt_reg == '0) begin
            state_reg   <= S_DONE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            result_reg  <= result_next;
            divzero_reg <= op_is_div(op_reg) && (operand_reg == '0);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_reg;
  assign done_o    = done_reg;
  assign result_o  = result_reg;
  assign divzero_o = divzero_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
// Directed vectors with hand-computed results. The driver pushes the expected
// result, divide-by-zero flag and done edge into a queue; a monitor pops and
// checks whenever done_o is seen, and also checks the busy cycle count.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  localparam int W = 32;

  logic         clk_i   = 1'b0;
  logic         rst_i   = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   op_i    = 2'b00;
  logic [W-1:0] a_i     = '0;
  logic [W-1:0] b_i     = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         divzero_o;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .divzero_o (divzero_o)
  );

  always #5 clk_i = ~clk_i;

  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    int           done_edge;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   busy_cnt   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: counts busy cycles and checks each done pulse against the queue.
  always @(negedge clk_i) begin
    if (rst_i) begin
      busy_cnt = 0;
    end else begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: actual done_o=1 result=%h required no done pulse", result_o);
        end else begin
          mon_e = sb.pop_front();
          $display("txn %s: result=%h divzero=%b edge=%0d busy_cycles=%0d",
                   mon_e.name, result_o, divzero_o, edge_cnt, busy_cnt);
          check({mon_e.name, "_result"},  result_o, mon_e.res);
          check({mon_e.name, "_divzero"}, W'(divzero_o), W'(mon_e.dz));
          check({mon_e.name, "_latency"}, W'(edge_cnt), W'(mon_e.done_edge));
          check({mon_e.name, "_busy"},    W'(busy_cnt), W'(W));
        end
        busy_cnt = 0;
      end
    end
  end

  // Launch one operation; inputs are scrambled once it has been accepted.
  task automatic launch(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic dz, input bit push,
                        input string name);
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    if (push) sb.push_back('{res, dz, edge_cnt + W, name});
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
  endtask

  // Bounded wait for all expected results to be consumed.
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: actual pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(negedge clk_i);
  endtask

  initial begin
    int n1;
    // Reset state
    #1 rst_i = 1'b1;
    #1;
    check("rst_busy",    W'(busy_o),    '0);
    check("rst_done",    W'(done_o),    '0);
    check("rst_result",  result_o,      '0);
    check("rst_divzero", W'(divzero_o), '0);
    @(negedge clk_i);
    rst_i = 1'b0;

    launch(OP_MUL,   32'd7,        32'd6,        32'd42,       1'b0, 1, "mul_7x6");      drain();
    launch(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1, "mulhu_ffxff");  drain();
    launch(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1, "mul_ffxff");    drain();
    launch(OP_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 1, "divu_100_7");   drain();
    launch(OP_REMU,  32'd100,      32'd7,        32'd2,        1'b0, 1, "remu_100_7");   drain();

    // Result holds while inputs wander with no start
    repeat (3) begin
      @(negedge clk_i);
      a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
    end
    check("hold_result", result_o, 32'd2);

    launch(OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1, "divu_5_0");     drain();
    launch(OP_REMU,  32'd5,        32'd0,        32'd5,        1'b1, 1, "remu_5_0");     drain();
    launch(OP_DIVU,  32'hFFFFFFFF, 32'h80000001, 32'd1,        1'b0, 1, "divu_big");     drain();
    launch(OP_REMU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 1, "remu_big");     drain();

    // Back-to-back: start held through DONE, operands changed mid-RUN
    @(negedge clk_i);
    op_i = OP_MUL; a_i = 32'd12345; b_i = 32'd1000; start_i = 1'b1;
    @(posedge clk_i); #1;
    n1 = edge_cnt;
    sb.push_back('{32'd12345000, 1'b0, n1 + W, "b2b_first"});
    @(negedge clk_i);
    a_i = 32'd3; b_i = 32'd3;
    repeat (W) @(posedge clk_i);
    @(posedge clk_i); #1;
    sb.push_back('{32'd9, 1'b0, n1 + 2 * W + 1, "b2b_second"});
    @(negedge clk_i);
    start_i = 1'b0;
    drain();

    // Async reset mid-DIVU: outputs clear without a clock edge, no done follows
    launch(OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 0, "divu_aborted");
    repeat (9) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    check("abort_busy",   W'(busy_o), '0);
    check("abort_done",   W'(done_o), '0);
    check("abort_result", result_o,   '0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);

    launch(OP_MUL, 32'd2, 32'd2, 32'd4, 1'b0, 1, "mul_2x2_after_rst"); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
